// File: rtl/axi_mem_bridge_pkg.sv
// Shared encodings for the AXI4 data-memory bridge: access sizes, response codes,
// FSM state values and the alignment check used on every accepted request.
package axi_mem_bridge_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_ID_W   = 4;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;
  localparam logic [1:0] MEM_SIZE_D = 2'd3;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR      = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_ADDR = 3'd3;
  localparam logic [2:0] ST_RD_DATA = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  // A size wider than the bus is treated like a misaligned access.
  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size,
                                      input int off_w);
    logic [2:0] mask;
    mask = 3'((4'd1 << size) - 4'd1);
    return (int'(size) > off_w) || ((off & mask) != 3'd0);
  endfunction

endpackage

// File: rtl/axi_mem_bridge_mem_align.sv
// Combinational lane steering: byte strobes and write shift for stores,
// extract plus sign/zero extension for loads.
module mem_align
  import axi_mem_bridge_pkg::*;
#(
  parameter int  DATA_W = DEF_DATA_W,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = $clog2(NB)
) (
  input  logic [OFF_W-1:0]  off_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [NB-1:0]     wstrb_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [NB-1:0]     base_en;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              sign;

  assign base_en = NB'((16'd1 << (5'd1 << size_i)) - 16'd1);
  assign wstrb_o = base_en << off_i;
  assign wdata_o = wdata_i << {off_i, 3'b000};
  assign shifted = rdata_i >> {off_i, 3'b000};

  // The unshifted strobe doubles as the byte mask of the extracted load value.
  for (genvar gi = 0; gi < NB; gi++) begin : g_mask
    assign mask[8*gi +: 8] = {8{base_en[gi]}};
  end

  always_comb begin
    case (size_i)
      MEM_SIZE_B: sign = shifted[7];
      MEM_SIZE_H: sign = shifted[15];
      MEM_SIZE_W: sign = shifted[31];
      default:    sign = shifted[DATA_W-1];
    endcase
  end

  assign rdata_o = (unsigned_i || !sign) ? (shifted & mask) : (shifted | ~mask);

endmodule

// File: rtl/axi_mem_bridge.sv
// Core-to-AXI4 data-memory master: one load or store at a time, pipeline stalled
// until the access retires; a simultaneous store+load runs the store first.
module axi_mem_bridge
  import axi_mem_bridge_pkg::*;
#(
  parameter int  ADDR_W = DEF_ADDR_W,
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  ID_W   = DEF_ID_W,
  parameter int  AXI_ID = 0,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_wr_en,
  input  logic              mem_rd_en,
  input  logic [ADDR_W-1:0] addr_mem_wr,
  input  logic [ADDR_W-1:0] addr_mem_rd,
  input  logic [DATA_W-1:0] data_mem_wr,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  output logic [DATA_W-1:0] data_mem_rd,
  output logic              core_stall,
  output logic              mem_err,
  output logic              awvalid,
  input  logic              awready,
  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awsize,
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic [NB-1:0]     wstrb,
  output logic              wlast,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  output logic              arvalid,
  input  logic              arready,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arsize,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d, is_wr_q, is_wr_d;
  logic              rd_pend_q, rd_pend_d, rd_mis_q, rd_mis_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d, err_q, err_d;
  logic [OFF_W-1:0]  off;
  logic [DATA_W-1:0] load_ext;
  logic              wr_bad, rd_bad;

  assign off    = is_wr_q ? wr_addr_q[OFF_W-1:0] : rd_addr_q[OFF_W-1:0];
  assign wr_bad = misaligned(3'(addr_mem_wr[OFF_W-1:0]), mem_size, OFF_W);
  assign rd_bad = misaligned(3'(addr_mem_rd[OFF_W-1:0]), mem_size, OFF_W);

  mem_align #(.DATA_W(DATA_W)) u_align (
    .off_i      (off),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .rdata_i    (rdata),
    .wstrb_o    (wstrb),
    .wdata_o    (wdata),
    .rdata_o    (load_ext)
  );

  // Valids come only from registered state, so payload stays stable while valid.
  assign awvalid = (state_q == ST_WR) && !aw_done_q;
  assign wvalid  = (state_q == ST_WR) && !w_done_q;
  assign bready  = (state_q == ST_WR_RESP);
  assign arvalid = (state_q == ST_RD_ADDR);
  assign rready  = (state_q == ST_RD_DATA);
  assign awid    = ID_W'(AXI_ID);
  assign arid    = ID_W'(AXI_ID);
  assign awaddr  = wr_addr_q;
  assign araddr  = rd_addr_q;
  assign awsize  = {1'b0, size_q};
  assign arsize  = {1'b0, size_q};
  assign wlast   = 1'b1;

  assign data_mem_rd = rdata_q;
  assign mem_err     = (state_q == ST_DONE) && err_q;
  assign core_stall  = ((state_q == ST_IDLE) && (mem_wr_en || mem_rd_en)) ||
                       ((state_q != ST_IDLE) && (state_q != ST_DONE)) ||
                       ((state_q == ST_DONE) && rd_pend_q);

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    size_d    = size_q;
    uns_d     = uns_q;
    is_wr_d   = is_wr_q;
    rd_pend_d = rd_pend_q;
    rd_mis_d  = rd_mis_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_wr_en || mem_rd_en) begin
          wr_addr_d = addr_mem_wr;
          rd_addr_d = addr_mem_rd;
          wdata_d   = data_mem_wr;
          size_d    = mem_size;
          uns_d     = mem_unsigned;
          is_wr_d   = mem_wr_en;
          rd_pend_d = mem_wr_en && mem_rd_en;
          rd_mis_d  = rd_bad;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          err_d     = mem_wr_en ? wr_bad : rd_bad;
          if (mem_wr_en ? wr_bad : rd_bad) begin
            state_d = ST_DONE;
            if (!mem_wr_en) rdata_d = '0;
          end else begin
            state_d = mem_wr_en ? ST_WR : ST_RD_ADDR;
          end
        end
      end
      ST_WR: begin
        if (awready) aw_done_d = 1'b1;
        if (wready)  w_done_d  = 1'b1;
        if ((aw_done_q || awready) && (w_done_q || wready)) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (bvalid) begin
          err_d   = (bresp != AXI_RESP_OKAY);
          state_d = ST_DONE;
        end
      end
      ST_RD_ADDR: begin
        if (arready) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (rvalid) begin
          err_d   = (rresp != AXI_RESP_OKAY);
          rdata_d = (rresp != AXI_RESP_OKAY) ? '0 : load_ext;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // A load queued behind a store chains straight into its address phase.
        if (rd_pend_q) begin
          rd_pend_d = 1'b0;
          is_wr_d   = 1'b0;
          err_d     = rd_mis_q;
          if (rd_mis_q) rdata_d = '0;
          state_d   = rd_mis_q ? ST_DONE : ST_RD_ADDR;
        end else begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      is_wr_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_mis_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      is_wr_q   <= is_wr_d;
      rd_pend_q <= rd_pend_d;
      rd_mis_q  <= rd_mis_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_mem_bridge.sv
// Directed bench for axi_mem_bridge: table of single accesses against a small AXI
// slave, plus hand-written store+load chaining, error pulse and mid-access reset.
module tb_axi_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_wr_en, mem_rd_en, mem_unsigned;
  logic [31:0] addr_mem_wr, addr_mem_rd;
  logic [63:0] data_mem_wr, data_mem_rd;
  logic [1:0]  mem_size;
  logic        core_stall, mem_err;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  awid, arid;
  logic [31:0] awaddr, araddr;
  logic [2:0]  awsize, arsize;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axi_mem_bridge dut (
    .clk(clk), .rst(rst), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .addr_mem_wr(addr_mem_wr), .addr_mem_rd(addr_mem_rd), .data_mem_wr(data_mem_wr),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .data_mem_rd(data_mem_rd),
    .core_stall(core_stall), .mem_err(mem_err),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  typedef struct {
    string       name;
    logic        wr, rd;
    logic [31:0] waddr, raddr;
    logic [63:0] wdat;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] rdat;
    logic [1:0]  bres, rres;
    int          aw_delay;
    int          lat, errs;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [63:0] wshift;
    int          aw_hs_exp, ar_hs_exp;
  } vec_t;

  int n_vec = 0, n_err = 0;

  // Slave configuration and observations
  int          cfg_aw_delay = 0;
  logic [63:0] cfg_rdata = '0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  int cyc = 0, aw_wait = 0;
  int aw_hs, w_hs, b_hs, ar_hs, b_cyc, ar_cyc;
  logic [31:0] seen_awaddr, seen_araddr;
  logic [2:0]  seen_awsize;
  logic [63:0] seen_wdata;
  logic [7:0]  seen_wstrb;
  int got_lat, got_errs, first_err_lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Simple AXI slave; updates on the falling edge so the DUT sees stable inputs.
  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; aw_wait = 0;
      end else begin
        if (awvalid) begin
          if (aw_wait >= cfg_aw_delay) begin
            awready = 1; aw_hs++; seen_awaddr = awaddr; seen_awsize = awsize;
          end else begin
            awready = 0; aw_wait++;
          end
        end else begin
          awready = 0; aw_wait = 0;
        end
        wready = wvalid;
        if (wvalid) begin w_hs++; seen_wdata = wdata; seen_wstrb = wstrb; end
        bvalid = bready; bresp = cfg_bresp;
        if (bready) begin b_hs++; b_cyc = cyc; end
        arready = arvalid;
        if (arvalid) begin ar_hs++; ar_cyc = cyc; seen_araddr = araddr; end
        rvalid = rready; rdata = cfg_rdata; rresp = cfg_rresp;
      end
    end
  end

  task automatic run_vec(input vec_t v);
    @(negedge clk); #1;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; b_cyc = 0; ar_cyc = 0;
    cfg_aw_delay = v.aw_delay; cfg_rdata = v.rdat; cfg_bresp = v.bres; cfg_rresp = v.rres;
    mem_wr_en = v.wr; mem_rd_en = v.rd; addr_mem_wr = v.waddr; addr_mem_rd = v.raddr;
    data_mem_wr = v.wdat; mem_size = v.size; mem_unsigned = v.uns;
    got_lat = 0; got_errs = 0; first_err_lat = 0;
    do begin
      @(negedge clk); #1;
      got_lat++;
      if (mem_err) begin
        got_errs++;
        if (first_err_lat == 0) first_err_lat = got_lat;
      end
    end while (core_stall && got_lat < 50);
    mem_wr_en = 0; mem_rd_en = 0;
    $display("vec %-8s lat=%0d errs=%0d data=%h aw=%0d w=%0d b=%0d ar=%0d",
             v.name, got_lat, got_errs, data_mem_rd, aw_hs, w_hs, b_hs, ar_hs);
    check({v.name, " latency"}, 64'(got_lat), 64'(v.lat));
    check({v.name, " err"}, 64'(got_errs), 64'(v.errs));
    check({v.name, " aw_hs"}, 64'(aw_hs), 64'(v.aw_hs_exp));
    check({v.name, " w_hs"}, 64'(w_hs), 64'(v.aw_hs_exp));
    check({v.name, " ar_hs"}, 64'(ar_hs), 64'(v.ar_hs_exp));
    if (v.rd) check({v.name, " rdata"}, data_mem_rd, v.data);
    if (v.aw_hs_exp > 0) begin
      check({v.name, " wstrb"}, 64'(seen_wstrb), 64'(v.strb));
      check({v.name, " wdata"}, seen_wdata, v.wshift);
      check({v.name, " awaddr"}, 64'(seen_awaddr), 64'(v.waddr));
      check({v.name, " awsize"}, 64'(seen_awsize), 64'(v.size));
    end
    if (v.ar_hs_exp > 0) check({v.name, " araddr"}, 64'(seen_araddr), 64'(v.raddr));
  endtask

  vec_t tbl[14];
  vec_t combo;

  initial begin
    //           name      wr rd waddr        raddr        wdat                    sz uns rdat                    bres rres awd lat errs data                    strb   wshift                 aw ar
    tbl[0]  = '{"LW",      0, 1, 32'h0,       32'h1004,    64'h0,                  2, 0, 64'h8000_0000_1234_5678, 0, 0, 0, 3, 0, 64'hFFFF_FFFF_8000_0000, 8'h00, 64'h0,                 0, 1};
    tbl[1]  = '{"SB",      1, 0, 32'h1003,    32'h0,       64'hAB,                 0, 0, 64'h0,                   0, 0, 4, 7, 0, 64'h0,                  8'h08, 64'h0000_0000_AB00_0000, 1, 0};
    tbl[2]  = '{"LBU",     0, 1, 32'h0,       32'h2007,    64'h0,                  0, 1, 64'h9C00_0000_0000_0000, 0, 0, 0, 3, 0, 64'h9C,                 8'h00, 64'h0,                 0, 1};
    tbl[3]  = '{"LB",      0, 1, 32'h0,       32'h2007,    64'h0,                  0, 0, 64'h9C00_0000_0000_0000, 0, 0, 0, 3, 0, 64'hFFFF_FFFF_FFFF_FF9C, 8'h00, 64'h0,                 0, 1};
    tbl[4]  = '{"LHmis",   0, 1, 32'h0,       32'h3001,    64'h0,                  1, 0, 64'h0,                   0, 0, 0, 1, 1, 64'h0,                  8'h00, 64'h0,                 0, 0};
    tbl[5]  = '{"SD",      1, 0, 32'h4000,    32'h0,       64'h0123_4567_89AB_CDEF, 3, 0, 64'h0,                  0, 0, 0, 3, 0, 64'h0,                  8'hFF, 64'h0123_4567_89AB_CDEF, 1, 0};
    tbl[6]  = '{"SH",      1, 0, 32'h4006,    32'h0,       64'hBEEF,               1, 0, 64'h0,                   0, 0, 0, 3, 0, 64'h0,                  8'hC0, 64'hBEEF_0000_0000_0000, 1, 0};
    tbl[7]  = '{"LHU",     0, 1, 32'h0,       32'h5002,    64'h0,                  1, 1, 64'h1111_2222_8765_3333, 0, 0, 0, 3, 0, 64'h8765,               8'h00, 64'h0,                 0, 1};
    tbl[8]  = '{"LH",      0, 1, 32'h0,       32'h5002,    64'h0,                  1, 0, 64'h1111_2222_8765_3333, 0, 0, 0, 3, 0, 64'hFFFF_FFFF_FFFF_8765, 8'h00, 64'h0,                 0, 1};
    tbl[9]  = '{"LD",      0, 1, 32'h0,       32'h6000,    64'h0,                  3, 0, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 0, 3, 0, 64'hDEAD_BEEF_CAFE_F00D, 8'h00, 64'h0,                 0, 1};
    tbl[10] = '{"LWrerr",  0, 1, 32'h0,       32'h7000,    64'h0,                  2, 0, 64'h0000_0000_1234_5678, 0, 2, 0, 3, 1, 64'h0,                  8'h00, 64'h0,                 0, 1};
    tbl[11] = '{"SWberr",  1, 0, 32'h7004,    32'h0,       64'h1234_5678,          2, 0, 64'h0,                   3, 0, 0, 3, 1, 64'h0,                  8'hF0, 64'h1234_5678_0000_0000, 1, 0};
    tbl[12] = '{"SWmis",   1, 0, 32'h7002,    32'h0,       64'h1234_5678,          2, 0, 64'h0,                   0, 0, 0, 1, 1, 64'h0,                  8'h00, 64'h0,                 0, 0};
    tbl[13] = '{"LWU",     0, 1, 32'h0,       32'h1004,    64'h0,                  2, 1, 64'h8000_0000_1234_5678, 0, 0, 0, 3, 0, 64'h0000_0000_8000_0000, 8'h00, 64'h0,                 0, 1};

    rst = 1; mem_wr_en = 0; mem_rd_en = 0; addr_mem_wr = 0; addr_mem_rd = 0;
    data_mem_wr = 0; mem_size = 0; mem_unsigned = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset awvalid", 64'(awvalid), 64'd0);
    check("reset wvalid", 64'(wvalid), 64'd0);
    check("reset arvalid", 64'(arvalid), 64'd0);
    check("reset bready", 64'(bready), 64'd0);
    check("reset rready", 64'(rready), 64'd0);
    check("reset mem_err", 64'(mem_err), 64'd0);
    check("reset data_mem_rd", data_mem_rd, 64'd0);
    check("reset core_stall", 64'(core_stall), 64'd0);
    check("wlast tie", 64'(wlast), 64'd1);
    rst = 0;

    for (int i = 0; i < 14; i++) begin
      run_vec(tbl[i]);
      // mem_err must be a single-cycle pulse
      if (tbl[i].errs > 0) begin
        @(negedge clk); #1;
        check({tbl[i].name, " err pulse end"}, 64'(mem_err), 64'd0);
        check({tbl[i].name, " stall after"}, 64'(core_stall), 64'd0);
      end
    end

    // Store and load together: store completes (with SLVERR) before the load's AR.
    combo = '{"ST+LD", 1, 1, 32'h8000, 32'h800C, 64'h55, 2, 0, 64'h1234_5678_0000_0000,
              2, 0, 0, 6, 1, 64'h1234_5678, 8'h0F, 64'h55, 1, 1};
    run_vec(combo);
    check("ST+LD err at store DONE", 64'(first_err_lat), 64'd3);
    check("ST+LD B before AR", 64'(ar_cyc > b_cyc), 64'd1);
    check("ST+LD b_hs", 64'(b_hs), 64'd1);
    $display("seq ST+LD b_cyc=%0d ar_cyc=%0d first_err_lat=%0d", b_cyc, ar_cyc, first_err_lat);

    // Reset in the middle of a store whose AW is stalled and a load still queued.
    @(negedge clk); #1;
    cfg_aw_delay = 100; cfg_bresp = 0; cfg_rresp = 0;
    mem_wr_en = 1; mem_rd_en = 1; addr_mem_wr = 32'h9000; addr_mem_rd = 32'h9008;
    data_mem_wr = 64'h77; mem_size = 2; mem_unsigned = 0;
    repeat (2) begin @(negedge clk); #1; end
    check("mid awvalid before rst", 64'(awvalid), 64'd1);
    check("mid stall before rst", 64'(core_stall), 64'd1);
    mem_wr_en = 0; mem_rd_en = 0;
    rst = 1;
    #1;
    check("mid rst awvalid", 64'(awvalid), 64'd0);
    check("mid rst wvalid", 64'(wvalid), 64'd0);
    check("mid rst arvalid", 64'(arvalid), 64'd0);
    check("mid rst bready", 64'(bready), 64'd0);
    check("mid rst stall", 64'(core_stall), 64'd0);
    $display("seq mid-reset awvalid=%b arvalid=%b stall=%b", awvalid, arvalid, core_stall);
    @(negedge clk); #1;
    rst = 0;
    repeat (3) begin
      @(negedge clk); #1;
      check("post rst no arvalid", 64'(arvalid), 64'd0);
    end
    run_vec(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
